// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: register-file write port widths shared by the writeback arbiter and its users
package rf_wb_arbiter_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam int STARVE_W = 4;
endpackage

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the regfile write port between pipeline WB (priority) and MUL/DIV with a starvation limit
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [RF_AW-1:0] s0_waddr,
  input  logic [RF_DW-1:0] s0_wdata,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [RF_AW-1:0] s1_waddr,
  input  logic [RF_DW-1:0] s1_wdata,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [RF_DW-1:0] rf_wdata,
  input  logic [RF_AW-1:0] raddr1,
  input  logic [RF_AW-1:0] raddr2,
  output logic             hit1,
  output logic             hit2
);
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                w_force;
  logic                w_g0;
  logic                w_g1;
  logic [RF_AW-1:0]    w_gaddr;
  logic [RF_DW-1:0]    w_gdata;
  always_comb begin
    w_force  = r_starve_cnt == STARVE_W'(STARVE_MAX);
    w_g1     = resetn && s1_valid && (w_force || !s0_valid);
    w_g0     = resetn && s0_valid && !w_g1;
    w_gaddr  = w_g1 ? s1_waddr : s0_waddr;
    w_gdata  = w_g1 ? s1_wdata : s0_wdata;
    s0_ready = w_g0;
    s1_ready = w_g1;
    hit1     = rf_we && (raddr1 == rf_waddr) && (raddr1 != '0);
    hit2     = rf_we && (raddr2 == rf_waddr) && (raddr2 != '0);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      r_starve_cnt <= '0;
    end else begin
      // r0 writes are consumed but never reach the regfile
      rf_we        <= (w_g0 || w_g1) && (w_gaddr != '0);
      rf_waddr     <= (w_g0 || w_g1) ? w_gaddr : rf_waddr;
      rf_wdata     <= (w_g0 || w_g1) ? w_gdata : rf_wdata;
      r_starve_cnt <= (!s1_valid || w_g1) ? '0 :
                      w_force ? r_starve_cnt : r_starve_cnt + STARVE_W'(1);
    end
  end
endmodule
